// File: rtl/rib_arbiter_pkg.sv
// Shared RIB bus definitions: pipeline hold encodings, master indices and the data-word zero constant.
package rib_arbiter_pkg;

    localparam int unsigned NUM_M  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 3;

    localparam logic [HOLD_W-1:0] HOLD_NONE  = 3'd0;
    localparam logic [HOLD_W-1:0] HOLD_PC    = 3'd1;
    localparam logic [HOLD_W-1:0] HOLD_IF_ID = 3'd2;
    localparam logic [HOLD_W-1:0] HOLD_ID_EX = 3'd3;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [IDX_W-1:0] M_DATA   = 2'd0;
    localparam logic [IDX_W-1:0] M_IFETCH = 2'd1;
    localparam logic [IDX_W-1:0] M_DEBUG  = 2'd2;

    // One-hot master vector to master index; an all-zero vector maps to M_DATA.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_M-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = M_DATA;
        if (oh[M_IFETCH]) idx = M_IFETCH;
        if (oh[M_DEBUG])  idx = M_DEBUG;
        return idx;
    endfunction

endpackage

// File: rtl/rib_prio_enc.sv
// Fixed-priority request encoder (debug > data > ifetch) with a per-master exclude mask.
module rib_prio_enc
    import rib_arbiter_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [NUM_M-1:0] excl,
    output logic [NUM_M-1:0] gnt,
    output logic             valid
);

    logic [NUM_M-1:0] eff;

    assign eff   = req & ~excl;
    assign valid = |eff;

    always_comb begin
        gnt = '0;
        if (eff[M_DEBUG]) begin
            gnt[M_DEBUG] = 1'b1;
        end else if (eff[M_DATA]) begin
            gnt[M_DATA] = 1'b1;
        end else if (eff[M_IFETCH]) begin
            gnt[M_IFETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Three-master RIB bus arbiter: fixed-priority grant, bus held until slave ack or timeout,
// back-to-back re-arbitration in the completion cycle, and pipeline hold request generation.
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [DATA_W-1:0] m2_wdata_i,
    output logic              m2_gnt_o,
    output logic              m2_rvalid_o,
    output logic [DATA_W-1:0] m2_rdata_o,

    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_rdata_i,

    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              timeout_o
);

    localparam int unsigned CNT_W = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_M-1:0]  req_vec;
    logic [NUM_M-1:0]  owner_oh;
    logic [NUM_M-1:0]  excl;
    logic [NUM_M-1:0]  win_oh;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              busy;
    logic              to_hit;
    logic              done;
    logic [NUM_M-1:0]  rvalid_vec;
    logic [DATA_W-1:0] rdata_sel;

    assign req_vec  = {m2_req_i, m1_req_i, m0_req_i};
    assign busy     = (state_q == BUSY);
    assign owner_oh = busy ? NUM_M'(3'b001 << owner_q) : '0;
    assign to_hit   = busy && (cnt_q == CNT_W'(TIMEOUT));
    assign done     = busy && (s_ack_i || to_hit);
    // The completing master is still requesting this cycle; keep it out of the next pick.
    assign excl     = done ? owner_oh : '0;

    rib_prio_enc u_prio_enc (
        .req   (req_vec),
        .excl  (excl),
        .gnt   (win_oh),
        .valid (win_vld)
    );

    assign win_idx = onehot_idx(win_oh);

    always_comb begin
        win_we    = m0_we_i;
        win_addr  = m0_addr_i;
        win_wdata = m0_wdata_i;
        case (win_idx)
            M_DEBUG: begin
                win_we    = m2_we_i;
                win_addr  = m2_addr_i;
                win_wdata = m2_wdata_i;
            end
            M_IFETCH: begin
                win_we    = m1_we_i;
                win_addr  = m1_addr_i;
                win_wdata = m1_wdata_i;
            end
            default: ;
        endcase
    end

    // State and transaction latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= M_DATA;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load a winner from IDLE or on completion, otherwise count wait cycles
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    owner_d = win_idx;
                    we_d    = win_we;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    cnt_d = '0;
                    if (win_vld) begin
                        owner_d = win_idx;
                        we_d    = win_we;
                        addr_d  = win_addr;
                        wdata_d = win_wdata;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_req_o   = busy;
    assign s_we_o    = busy & we_q;
    assign s_addr_o  = busy ? addr_q  : '0;
    assign s_wdata_o = busy ? wdata_q : '0;

    assign m0_gnt_o  = owner_oh[M_DATA];
    assign m1_gnt_o  = owner_oh[M_IFETCH];
    assign m2_gnt_o  = owner_oh[M_DEBUG];

    // A real ack beats a coinciding timeout
    assign rvalid_vec = done ? owner_oh : '0;
    assign rdata_sel  = s_ack_i ? s_rdata_i : ERR_DATA;
    assign timeout_o  = to_hit & ~s_ack_i;

    assign m0_rvalid_o = rvalid_vec[M_DATA];
    assign m1_rvalid_o = rvalid_vec[M_IFETCH];
    assign m2_rvalid_o = rvalid_vec[M_DEBUG];

    assign m0_rdata_o = rvalid_vec[M_DATA]   ? rdata_sel : DATA_W'(ZERO_WORD);
    assign m1_rdata_o = rvalid_vec[M_IFETCH] ? rdata_sel : DATA_W'(ZERO_WORD);
    assign m2_rdata_o = rvalid_vec[M_DEBUG]  ? rdata_sel : DATA_W'(ZERO_WORD);

    // Debug accesses never stall the pipeline
    always_comb begin
        hold_flag_o = HOLD_NONE;
        if (m0_req_i && !m0_rvalid_o) begin
            hold_flag_o = HOLD_ID_EX;
        end else if (m1_req_i && !m1_rvalid_o) begin
            hold_flag_o = HOLD_PC;
        end
    end

endmodule

// File: tb/tb_rib_arbiter.sv
// Randomized bench for rib_arbiter: masters and slave driven from $urandom, a transaction-level
// reference model predicts bus ownership and completions, and a monitor scores every rvalid.
module tb_rib_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
    localparam int          NCYC    = 4000;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        to;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];
    logic        s_req, s_we, s_ack, timeout;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  hold;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sbq[$];

    // Model state: who owns the bus, when its transaction began, and when the slave will answer
    bit   m_busy;
    int   m_owner, m_start, m_delay;
    bit   drop [3];
    bit   cur_busy, cur_done;
    bit   rst_done;

    always #5 clk = ~clk;

    rib_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .ERR_DATA(ERR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req_i   (req[0]),
        .m0_we_i    (we[0]),
        .m0_addr_i  (addr[0]),
        .m0_wdata_i (wdata[0]),
        .m0_gnt_o   (gnt[0]),
        .m0_rvalid_o(rvalid[0]),
        .m0_rdata_o (rdata[0]),
        .m1_req_i   (req[1]),
        .m1_we_i    (we[1]),
        .m1_addr_i  (addr[1]),
        .m1_wdata_i (wdata[1]),
        .m1_gnt_o   (gnt[1]),
        .m1_rvalid_o(rvalid[1]),
        .m1_rdata_o (rdata[1]),
        .m2_req_i   (req[2]),
        .m2_we_i    (we[2]),
        .m2_addr_i  (addr[2]),
        .m2_wdata_i (wdata[2]),
        .m2_gnt_o   (gnt[2]),
        .m2_rvalid_o(rvalid[2]),
        .m2_rdata_o (rdata[2]),
        .s_req_o    (s_req),
        .s_we_o     (s_we),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_ack_i    (s_ack),
        .s_rdata_i  (s_rdata),
        .hold_flag_o(hold),
        .timeout_o  (timeout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Priority order debug, data, ifetch; ex names a master to skip (-1 for none)
    function automatic int pick(input logic [2:0] r, input int ex);
        int order [3] = '{2, 0, 1};
        for (int k = 0; k < 3; k++) begin
            if (r[order[k]] && order[k] != ex) return order[k];
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (drop[i]) begin
                req[i]  = 1'b0;
                drop[i] = 1'b0;
            end
            if (!req[i] && ($urandom % 3 == 0)) begin
                req[i]   = 1'b1;
                we[i]    = 1'($urandom);
                addr[i]  = $urandom;
                wdata[i] = $urandom;
            end
        end
        s_ack   = m_busy ? ((cyc - m_start) >= m_delay) : ($urandom % 4 == 0);
        s_rdata = $urandom;
    endtask

    // Compare bus-side outputs for the current cycle, then advance the model
    task automatic evaluate();
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_hold;
        bit          rv0, rv1, to;
        int          w;
        cur_busy = m_busy;
        cur_done = m_busy && (s_ack || (cyc - m_start) == TIMEOUT);
        to       = cur_done && !s_ack;
        exp_gnt  = m_busy ? 3'(1 << m_owner) : 3'b000;
        rv0      = cur_done && m_owner == 0;
        rv1      = cur_done && m_owner == 1;
        exp_hold = (req[0] && !rv0) ? 3'd3 : ((req[1] && !rv1) ? 3'd1 : 3'd0);

        chk("s_req", 64'(s_req), 64'(m_busy));
        chk("s_we", 64'(s_we), m_busy ? 64'(we[m_owner]) : 64'd0);
        chk("s_addr", 64'(s_addr), m_busy ? 64'(addr[m_owner]) : 64'd0);
        chk("s_wdata", 64'(s_wdata), m_busy ? 64'(wdata[m_owner]) : 64'd0);
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("hold_flag", 64'(hold), 64'(exp_hold));

        if (cur_done) begin
            sbq.push_back('{m_owner, s_ack ? s_rdata : ERR, to, cyc});
            drop[m_owner] = 1'b1;
        end
        if (!m_busy || cur_done) begin
            w = pick(req, cur_done ? m_owner : -1);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_start = cyc + 1;
                m_delay = int'($urandom_range(0, 6));
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    // Monitor: every rvalid pops one expected completion
    initial begin
        exp_t e;
        int   nv;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                nv = 0;
                for (int i = 0; i < 3; i++) begin
                    if (rvalid[i]) begin
                        nv++;
                        if (sbq.size() == 0) begin
                            chk("unexpected_rvalid", 64'(i), 64'hFF);
                        end else begin
                            e = sbq.pop_front();
                            chk("rvalid_master", 64'(i), 64'(e.idx));
                            chk("rdata", 64'(rdata[i]), 64'(e.data));
                            chk("timeout_o", 64'(timeout), 64'(e.to));
                            chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                        end
                    end else begin
                        chk("rdata_idle", 64'(rdata[i]), 64'd0);
                    end
                end
                if (nv > 1) chk("multi_rvalid", 64'(nv), 64'd1);
                if (nv == 0) begin
                    chk("timeout_idle", 64'(timeout), 64'd0);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("missing_rvalid", 64'(e.idx), 64'hFF);
                    end
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        s_ack   = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
            drop[i]  = 1'b0;
        end
        m_busy   = 1'b0;
        rst_done = 1'b0;

        #2 req[1] = 1'b1;
        #5;
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_s_addr", 64'(s_addr), 64'd0);
        chk("rst_rdata0", 64'(rdata[0]), 64'd0);
        chk("rst_hold_from_inputs", 64'(hold), 64'd1);
        #1 req[1] = 1'b0;
        #4 rst_n = 1'b1;

        repeat (NCYC) begin
            @(posedge clk);
            cyc++;
            #1;
            drive();
            @(negedge clk);
            evaluate();
            // Asynchronous reset in the middle of a transaction that is not completing
            if (!rst_done && cyc > NCYC / 2 && cur_busy && !cur_done) begin
                rst_done = 1'b1;
                #2;
                rst_n = 1'b0;
                req   = '0;
                s_ack = 1'b0;
                #1;
                chk("midrst_s_req", 64'(s_req), 64'd0);
                chk("midrst_rvalid", 64'(rvalid), 64'd0);
                chk("midrst_gnt", 64'(gnt), 64'd0);
                @(posedge clk);
                cyc++;
                #1;
                chk("midrst_s_req_held", 64'(s_req), 64'd0);
                @(negedge clk);
                m_busy = 1'b0;
                for (int i = 0; i < 3; i++) drop[i] = 1'b0;
                sbq.delete();
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
